// File: rtl/sm3_msg_pkr_if.sv
// sm3_msg_pkr_if
//   Bundles the two handshake buses around the SM3 message packer:
//   - byte side : byte_inpt_d / byte_inpt_vld / byte_inpt_lst in, byte_inpt_rdy out
//   - word side : msg_inpt_d / msg_inpt_vld_byte / msg_inpt_vld / msg_inpt_lst out,
//                 msg_inpt_rdy in
//   Modport 'slave' is the packer's view; 'master' is the view of whoever drives
//   the byte stream and consumes the packed words.
interface sm3_msg_pkr_if #(
    parameter int unsigned INPT_DW = 32
);
    localparam int unsigned INPT_BYTE_DW = INPT_DW / 8;

    logic [7:0]              byte_inpt_d;
    logic                    byte_inpt_vld;
    logic                    byte_inpt_lst;
    logic                    byte_inpt_rdy;

    logic [INPT_DW-1:0]      msg_inpt_d;
    logic [INPT_BYTE_DW-1:0] msg_inpt_vld_byte;
    logic                    msg_inpt_vld;
    logic                    msg_inpt_lst;
    logic                    msg_inpt_rdy;

    modport slave (
        input  byte_inpt_d,
        input  byte_inpt_vld,
        input  byte_inpt_lst,
        output byte_inpt_rdy,
        output msg_inpt_d,
        output msg_inpt_vld_byte,
        output msg_inpt_vld,
        output msg_inpt_lst,
        input  msg_inpt_rdy
    );

    modport master (
        output byte_inpt_d,
        output byte_inpt_vld,
        output byte_inpt_lst,
        input  byte_inpt_rdy,
        input  msg_inpt_d,
        input  msg_inpt_vld_byte,
        input  msg_inpt_vld,
        input  msg_inpt_lst,
        output msg_inpt_rdy
    );
endinterface

// File: rtl/sm3_msg_pkr.sv
// sm3_msg_pkr
//   Packs a byte stream big-endian into INPT_DW-bit message words for the SM3
//   input bus. One byte per cycle is sustained while the word side is ready; a
//   word completed while the output register is still occupied is parked in a
//   single pending register and the byte side stalls until it drains.
//
// Ports
//   clk          : clock
//   rst          : asynchronous active-high reset
//   bus          : sm3_msg_pkr_if.slave (byte input handshake, word output handshake)
//   msg_done     : pulse in the cycle the last word of a message is handshaken
//   msg_byte_cnt : byte length of the most recently completed message
module sm3_msg_pkr #(
    parameter int unsigned INPT_DW = 32
) (
    input  logic                clk,
    input  logic                rst,
    sm3_msg_pkr_if.slave        bus,
    output logic                msg_done,
    output logic [60:0]         msg_byte_cnt
);
    localparam int unsigned BW = INPT_DW / 8;
    localparam int unsigned IW = $clog2(BW);

    typedef enum logic {
        StPack,
        StHold
    } state_e;

    state_e             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [INPT_DW-9:0] acc_q, acc_d;

    // Presented word
    logic [INPT_DW-1:0] out_d_q, out_d_d;
    logic [BW-1:0]      out_vb_q, out_vb_d;
    logic               out_lst_q, out_lst_d;
    logic               out_vld_q, out_vld_d;
    logic [60:0]        out_len_q, out_len_d;

    // Word parked while the output register is busy
    logic [INPT_DW-1:0] pend_d_q, pend_d_d;
    logic [BW-1:0]      pend_vb_q, pend_vb_d;
    logic               pend_lst_q, pend_lst_d;
    logic [60:0]        pend_len_q, pend_len_d;

    logic [60:0]        run_cnt_q, run_cnt_d;
    logic [60:0]        byte_cnt_q, byte_cnt_d;

    logic               byte_hs;
    logic               word_hs;
    logic               out_free;
    logic               word_end;
    logic [INPT_DW-1:0] ins_word;
    logic [INPT_DW-1:0] fmt_d;
    logic [BW-1:0]      fmt_vb;
    logic [60:0]        fmt_len;

    assign byte_hs  = bus.byte_inpt_vld & (state_q == StPack);
    assign word_hs  = out_vld_q & bus.msg_inpt_rdy;
    assign out_free = ~out_vld_q | bus.msg_inpt_rdy;
    assign word_end = byte_hs & ((idx_q == IW'(BW - 1)) | bus.byte_inpt_lst);
    // Length travels with the last word so a following message can start counting
    // before this one's last word has drained.
    assign fmt_len  = run_cnt_q + 61'd1;

    // Insert the incoming byte at lane idx (lane 0 = MSB), then zero every lane
    // past it so stale accumulator bytes from an earlier word never leak out.
    always_comb begin
        ins_word = {acc_q, 8'h00};
        fmt_vb   = '0;
        for (int i = 0; i < BW; i++) begin
            if (idx_q == IW'(i)) begin
                ins_word[INPT_DW-1-8*i -: 8] = bus.byte_inpt_d;
            end
            fmt_vb[BW-1-i] = (IW'(i) <= idx_q);
        end
        fmt_d = ins_word;
        for (int i = 0; i < BW; i++) begin
            if (!fmt_vb[BW-1-i]) begin
                fmt_d[INPT_DW-1-8*i -: 8] = 8'h00;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        out_d_d    = out_d_q;
        out_vb_d   = out_vb_q;
        out_lst_d  = out_lst_q;
        out_vld_d  = out_vld_q;
        out_len_d  = out_len_q;
        pend_d_d   = pend_d_q;
        pend_vb_d  = pend_vb_q;
        pend_lst_d = pend_lst_q;
        pend_len_d = pend_len_q;
        run_cnt_d  = run_cnt_q;
        byte_cnt_d = byte_cnt_q;

        if (word_hs) begin
            out_vld_d = 1'b0;
            if (out_lst_q) begin
                byte_cnt_d = out_len_q;
            end
        end

        if (byte_hs) begin
            acc_d     = ins_word[INPT_DW-1:8];
            idx_d     = word_end ? '0 : idx_q + 1'b1;
            run_cnt_d = bus.byte_inpt_lst ? '0 : fmt_len;
        end

        unique case (state_q)
            StPack: begin
                if (word_end) begin
                    if (out_free) begin
                        out_d_d   = fmt_d;
                        out_vb_d  = fmt_vb;
                        out_lst_d = bus.byte_inpt_lst;
                        out_len_d = fmt_len;
                        out_vld_d = 1'b1;
                    end else begin
                        pend_d_d   = fmt_d;
                        pend_vb_d  = fmt_vb;
                        pend_lst_d = bus.byte_inpt_lst;
                        pend_len_d = fmt_len;
                        state_d    = StHold;
                    end
                end
            end
            StHold: begin
                // out_vld is necessarily high here, so out_free means the current
                // word handshakes this cycle and the parked one replaces it.
                if (out_free) begin
                    out_d_d   = pend_d_q;
                    out_vb_d  = pend_vb_q;
                    out_lst_d = pend_lst_q;
                    out_len_d = pend_len_q;
                    out_vld_d = 1'b1;
                    state_d   = StPack;
                end
            end
            default: state_d = StPack;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StPack;
            idx_q      <= '0;
            acc_q      <= '0;
            out_d_q    <= '0;
            out_vb_q   <= '0;
            out_lst_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            out_len_q  <= '0;
            pend_d_q   <= '0;
            pend_vb_q  <= '0;
            pend_lst_q <= 1'b0;
            pend_len_q <= '0;
            run_cnt_q  <= '0;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            out_d_q    <= out_d_d;
            out_vb_q   <= out_vb_d;
            out_lst_q  <= out_lst_d;
            out_vld_q  <= out_vld_d;
            out_len_q  <= out_len_d;
            pend_d_q   <= pend_d_d;
            pend_vb_q  <= pend_vb_d;
            pend_lst_q <= pend_lst_d;
            pend_len_q <= pend_len_d;
            run_cnt_q  <= run_cnt_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    // Ready is a pure state decode: no path from msg_inpt_rdy.
    assign bus.byte_inpt_rdy     = (state_q == StPack);
    assign bus.msg_inpt_d        = out_d_q;
    assign bus.msg_inpt_vld_byte = out_vb_q;
    assign bus.msg_inpt_vld      = out_vld_q;
    assign bus.msg_inpt_lst      = out_lst_q;
    assign msg_done              = word_hs & out_lst_q;
    assign msg_byte_cnt          = byte_cnt_q;
endmodule
